// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the branch resolver: op kinds, comparator modes, FSM states.
// Optional statistics counters in the top level are enabled with BRANCH_STATS_EN.
package branch_resolver_pkg;

    localparam int XLEN_DEFAULT        = 32;
    localparam int FLUSH_DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'b00,
        KIND_BRANCH = 2'b01,
        KIND_JAL    = 2'b10,
        KIND_JALR   = 2'b11
    } kind_e;

    // Same encoding as the upstream comparator; carried through for reference only.
    localparam logic [2:0] CMP_LT  = 3'b000;
    localparam logic [2:0] CMP_LTU = 3'b001;
    localparam logic [2:0] CMP_GE  = 3'b010;
    localparam logic [2:0] CMP_GEU = 3'b011;
    localparam logic [2:0] CMP_EQ  = 3'b100;
    localparam logic [2:0] CMP_NEQ = 3'b101;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic logic resolve_taken(input logic [1:0] kind, input logic cmp_bit);
        return (kind == KIND_BRANCH) ? cmp_bit : kind[1];
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Op/result bundle between the ID/EX operand stage, the branch resolver and EX/MEM.
// master = surrounding pipeline, slave = resolver.
interface branch_resolver_if #(parameter int XLEN = 32);

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_kind;
    logic [2:0]      in_cmp_mode;
    logic [XLEN-1:0] in_cmp_result;
    logic            in_pred_taken;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_rs1;

    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_link;
    logic            out_misalign;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output in_valid, in_kind, in_cmp_mode, in_cmp_result, in_pred_taken,
               in_pc, in_imm, in_rs1, out_ready,
        input  in_ready, out_valid, out_taken, out_link, out_misalign,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, in_kind, in_cmp_mode, in_cmp_result, in_pred_taken,
               in_pc, in_imm, in_rs1, out_ready,
        output in_ready, out_valid, out_taken, out_link, out_misalign,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/branch_resolver_target_calc.sv
// Combinational direction, target, link and alignment computation for one control-flow op.
module branch_target_calc
    import branch_resolver_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [1:0]      i_kind,
    input  logic            i_cmp_bit,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    output logic            o_taken,
    output logic [XLEN-1:0] o_target,
    output logic [XLEN-1:0] o_link,
    output logic            o_misalign
);

    logic [XLEN-1:0] w_jalr_sum;

    assign w_jalr_sum = i_rs1 + i_imm;
    assign o_taken    = resolve_taken(i_kind, i_cmp_bit);
    assign o_link     = i_pc + XLEN'(4);

    // JALR clears bit 0 of the computed address; everything else is pc-relative.
    always_comb begin
        o_target = i_pc + i_imm;
        if (i_kind == KIND_JALR) begin
            o_target = {w_jalr_sum[XLEN-1:1], 1'b0};
        end
    end

    assign o_misalign = o_taken & (o_target[1:0] != 2'b00);

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: registers one op, redirects on mispredict, squashes wrong path.
// Define BRANCH_STATS_EN to add saturating resolved/mispredict counters.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    branch_resolver_if.slave  bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       stat_resolved,
    output logic [31:0]       stat_mispredict
`endif
);

    state_e          r_state;
    state_e          w_next_state;
    logic [2:0]      r_flush_cnt;

    logic            r_out_valid;
    logic            r_out_taken;
    logic [XLEN-1:0] r_out_link;
    logic            r_out_misalign;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_link;
    logic            w_misalign;
    logic            w_accept;
    logic            w_resolve;
    logic            w_mispredict;
    logic            w_start_flush;
    logic            w_unused;

    branch_target_calc #(.XLEN(XLEN)) u_target_calc (
        .i_kind     (bus.in_kind),
        .i_cmp_bit  (bus.in_cmp_result[0]),
        .i_pc       (bus.in_pc),
        .i_imm      (bus.in_imm),
        .i_rs1      (bus.in_rs1),
        .o_taken    (w_taken),
        .o_target   (w_target),
        .o_link     (w_link),
        .o_misalign (w_misalign)
    );

    assign w_unused      = ^{bus.in_cmp_mode, bus.in_cmp_result[XLEN-1:1]};
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_resolve     = w_accept & (r_state == ST_RUN);
    assign w_mispredict  = (bus.in_kind != KIND_NONE) & ~w_misalign & (w_taken != bus.in_pred_taken);
    assign w_start_flush = w_resolve & w_mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_start_flush) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == 3'd0 || (w_accept && r_flush_cnt == 3'd1)) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // Wrong-path ops are always accepted during a flush, even while a result is held.
    always_comb begin
        bus.in_ready = (r_state == ST_FLUSH) | ~r_out_valid | bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= 3'd0;
        end else if (w_start_flush) begin
            r_flush_cnt <= 3'(FLUSH_DEPTH);
        end else if (r_state == ST_FLUSH && w_accept && r_flush_cnt != 3'd0) begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid      <= 1'b0;
            r_out_taken      <= 1'b0;
            r_out_link       <= '0;
            r_out_misalign   <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_start_flush;
            if (w_start_flush) begin
                r_redirect_pc <= w_taken ? w_target : w_link;
            end
            if (w_resolve) begin
                r_out_valid    <= 1'b1;
                r_out_taken    <= w_taken;
                r_out_link     <= w_link;
                r_out_misalign <= w_misalign;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid      = r_out_valid;
    assign bus.out_taken      = r_out_taken;
    assign bus.out_link       = r_out_link;
    assign bus.out_misalign   = r_out_misalign;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_resolved   <= '0;
            r_stat_mispredict <= '0;
        end else if (w_resolve && bus.in_kind != KIND_NONE) begin
            if (r_stat_resolved != 32'hFFFF_FFFF) begin
                r_stat_resolved <= r_stat_resolved + 32'd1;
            end
            if (w_mispredict && r_stat_mispredict != 32'hFFFF_FFFF) begin
                r_stat_mispredict <= r_stat_mispredict + 32'd1;
            end
        end
    end

    assign stat_resolved   = r_stat_resolved;
    assign stat_mispredict = r_stat_mispredict;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: expected results are queued at accept and
// compared when the DUT hands a result or redirect downstream.
module tb_branch_resolver;

    localparam int XLEN        = 32;
    localparam int FLUSH_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_resolver_if #(.XLEN(XLEN)) bus();

`ifdef BRANCH_STATS_EN
    logic [31:0] statResolved;
    logic [31:0] statMispredict;
    int          modelResolved = 0;
    int          modelMispredict = 0;
`endif

    branch_resolver #(.XLEN(XLEN), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BRANCH_STATS_EN
        ,
        .stat_resolved   (statResolved),
        .stat_mispredict (statMispredict)
`endif
    );

    typedef struct packed {
        logic        taken;
        logic [31:0] link;
        logic        misalign;
    } outExp_t;

    outExp_t     outQ[$];
    logic [31:0] redirQ[$];
    int          checkCount = 0;
    int          errorCount = 0;
    int          flushLeft  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference behaviour of one op, written straight from the op semantics.
    function automatic void modelOp(input logic [1:0] kind, input logic cmpBit, input logic pred,
                                    input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                                    output logic taken, output logic [31:0] link, output logic mis,
                                    output logic misp, output logic [31:0] rpc);
        logic [31:0] tgt;
        taken = (kind == 2'b01) ? cmpBit : (kind == 2'b10 || kind == 2'b11);
        tgt   = (kind == 2'b11) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        link  = pc + 32'd4;
        mis   = taken && (tgt[1:0] != 2'b00);
        misp  = (kind != 2'b00) && !mis && (taken != pred);
        rpc   = taken ? tgt : link;
    endfunction

    task automatic applyStimulus(input logic [1:0] kind, input logic cmpBit, input logic pred,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
        logic [31:0] res;
        bit          ready;
        bit          accepted;
        outExp_t     e;
        logic        misp;
        logic [31:0] rpc;
        accepted = 0;
        @(negedge clk);
        res    = $urandom();
        res[0] = cmpBit;
        bus.in_kind       = kind;
        bus.in_cmp_mode   = 3'b100;
        bus.in_cmp_result = res;
        bus.in_pred_taken = pred;
        bus.in_pc         = pc;
        bus.in_imm        = imm;
        bus.in_rs1        = rs1;
        bus.in_valid      = 1'b1;
        for (int t = 0; t < 50; t++) begin
            #1 ready = bus.in_ready;
            @(posedge clk);
            if (ready) begin
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            checkOutput("accept timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        if (flushLeft > 0) begin
            flushLeft--;
        end else begin
            modelOp(kind, cmpBit, pred, pc, imm, rs1, e.taken, e.link, e.misalign, misp, rpc);
            outQ.push_back(e);
`ifdef BRANCH_STATS_EN
            if (kind != 2'b00) modelResolved++;
            if (misp) modelMispredict++;
`endif
            if (misp) begin
                redirQ.push_back(rpc);
                flushLeft = FLUSH_DEPTH;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every downstream handshake and every redirect pulse.
    initial begin
        outExp_t     e;
        logic [31:0] p;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (outQ.size() == 0) begin
                        checkOutput("unexpected out_valid", 32'd1, 32'd0);
                    end else begin
                        e = outQ.pop_front();
                        checkOutput("out_taken", 32'(bus.out_taken), 32'(e.taken));
                        checkOutput("out_link", bus.out_link, e.link);
                        checkOutput("out_misalign", 32'(bus.out_misalign), 32'(e.misalign));
                    end
                end
                if (bus.redirect_valid) begin
                    if (redirQ.size() == 0) begin
                        checkOutput("unexpected redirect", 32'd1, 32'd0);
                    end else begin
                        p = redirQ.pop_front();
                        checkOutput("redirect_pc", bus.redirect_pc, p);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_kind       = 2'b00;
        bus.in_cmp_mode   = 3'b000;
        bus.in_cmp_result = '0;
        bus.in_pred_taken = 1'b0;
        bus.in_pc         = '0;
        bus.in_imm        = '0;
        bus.in_rs1        = '0;
        bus.out_ready     = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset redirect_valid", 32'(bus.redirect_valid), 32'd0);
        checkOutput("reset redirect_pc", bus.redirect_pc, 32'd0);
        checkOutput("reset out_link", bus.out_link, 32'd0);
        checkOutput("reset out_taken", 32'(bus.out_taken), 32'd0);
        rst = 1'b0;

        // Taken branch predicted not-taken, then two wrong-path ops that would redirect if resolved.
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0);
        applyStimulus(2'b10, 1'b0, 1'b0, 32'h104, 32'h80, 32'h0);
        applyStimulus(2'b10, 1'b0, 1'b0, 32'h108, 32'h80, 32'h0);
        applyStimulus(2'b01, 1'b0, 1'b0, 32'h300, 32'h8, 32'h0);

        applyStimulus(2'b01, 1'b0, 1'b1, 32'h200, 32'h40, 32'h0);
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h204, 32'h10, 32'h0);
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h208, 32'h10, 32'h0);
        applyStimulus(2'b01, 1'b1, 1'b1, 32'h280, 32'h10, 32'h0);

        applyStimulus(2'b11, 1'b0, 1'b1, 32'h40, 32'h4, 32'h1001);
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h40, 32'h4, 32'h1001);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h44, 32'h0, 32'h0);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h48, 32'h0, 32'h0);

        // Misaligned JAL: no redirect and no flush, so the following mispredict must resolve.
        applyStimulus(2'b10, 1'b0, 1'b0, 32'h10, 32'h6, 32'h0);
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h500, 32'h10, 32'h0);
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h504, 32'h10, 32'h0);
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h508, 32'h10, 32'h0);

        applyStimulus(2'b00, 1'b1, 1'b1, 32'h50C, 32'h10, 32'h0);
        applyStimulus(2'b11, 1'b0, 1'b1, 32'h60, 32'h0, 32'h1003);
        applyStimulus(2'b10, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h8, 32'h0);
        applyStimulus(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0);
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h4, 32'h10, 32'h0);
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h8, 32'h10, 32'h0);
        idle(3);

        // Downstream stall on a correctly predicted op: result held, input blocked.
        bus.out_ready = 1'b0;
        applyStimulus(2'b10, 1'b0, 1'b1, 32'h600, 32'h100, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #2;
            checkOutput("hold out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("hold out_link", bus.out_link, 32'h604);
            checkOutput("hold out_taken", 32'(bus.out_taken), 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        idle(2);

        // Stall on a mispredict: one redirect only, and the flush still accepts input.
        bus.out_ready = 1'b0;
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h700, 32'h30, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #2;
            checkOutput("flush hold out_link", bus.out_link, 32'h704);
            checkOutput("flush in_ready", 32'(bus.in_ready), 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        applyStimulus(2'b10, 1'b0, 1'b0, 32'h704, 32'h40, 32'h0);
        applyStimulus(2'b10, 1'b0, 1'b0, 32'h708, 32'h40, 32'h0);
        applyStimulus(2'b01, 1'b0, 1'b0, 32'h70C, 32'h40, 32'h0);

        // Reset with one wrong-path slot still pending.
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h800, 32'h40, 32'h0);
        applyStimulus(2'b10, 1'b0, 1'b0, 32'h804, 32'h40, 32'h0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("mid-flush reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid-flush reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("mid-flush reset redirect_valid", 32'(bus.redirect_valid), 32'd0);
        rst = 1'b0;
        flushLeft = 0;
`ifdef BRANCH_STATS_EN
        modelResolved = 0;
        modelMispredict = 0;
`endif
        applyStimulus(2'b01, 1'b0, 1'b0, 32'h900, 32'h4, 32'h0);
        applyStimulus(2'b10, 1'b0, 1'b1, 32'h904, 32'h20, 32'h0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom() & 32'hFFFF_FFFC, 32'($urandom_range(0, 2047)) - 32'd1024, $urandom());
        end
        idle(5);

        checkOutput("result queue drained", 32'(outQ.size()), 32'd0);
        checkOutput("redirect queue drained", 32'(redirQ.size()), 32'd0);
`ifdef BRANCH_STATS_EN
        checkOutput("stat_resolved", statResolved, 32'(modelResolved));
        checkOutput("stat_mispredict", statMispredict, 32'(modelMispredict));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
